wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 34 +++
 tb/tb_wb_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back mux plus a 31x32 register file.
// It has two bypassed combinational read ports and a committed-write counter.
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctrl,
  input  logic [31:0] wb_read_data,
  input  logic [31:0] wb_alu_result,
  input  logic [4:0]  wb_write_reg,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic [15:0] wr_count
);
  logic [31:0] regs [1:31];
  assign wb_data = wb_ctrl[0] ? wb_read_data : wb_alu_result;
  assign wb_we   = wb_ctrl[1] && (wb_write_reg != 5'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wb_we) begin
      regs[wb_write_reg] <= wb_data;
      wr_count <= wr_count + 16'd1;
    end
  // Address 0 wins over the bypass; the bypass wins over stored data.
  always_comb begin
    rs_data = (rs_addr == 5'd0) ? 32'd0 : (wb_we && rs_addr == wb_write_reg) ? wb_data : regs[rs_addr];
    rt_data = (rt_addr == 5'd0) ? 32'd0 : (wb_we && rt_addr == wb_write_reg) ? wb_data : regs[rt_addr];
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile.
// Stimulus queues expected values; a negedge monitor pops them and compares them.
module tb_wb_regfile;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  wb_ctrl = 0;
  logic [31:0] wb_read_data = 0, wb_alu_result = 0;
  logic [4:0]  wb_write_reg = 0, rs_addr = 0, rt_addr = 0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_we;
  logic [15:0] wr_count;
  int total = 0, bad = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;
  item_t q[$];

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_ctrl(wb_ctrl), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data), .wb_we(wb_we),
    .wb_data(wb_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    return sel == 0 ? rs_data : sel == 1 ? rt_data : sel == 2 ? {31'd0, wb_we} :
           sel == 3 ? wb_data : {16'd0, wr_count};
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] act;
      it = q.pop_front();
      act = observe(it.sel);
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", it.name, act, it.exp);
      end
    end

  task automatic expect_val(string name, int sel, logic [31:0] exp);
    q.push_back('{name, sel, exp});
  endtask

  task automatic apply(logic [1:0] c, logic [31:0] rd, logic [31:0] alu, logic [4:0] wr,
                       logic [4:0] rs, logic [4:0] rt);
    @(posedge clk);
    #1;
    wb_ctrl = c; wb_read_data = rd; wb_alu_result = alu; wb_write_reg = wr;
    rs_addr = rs; rt_addr = rt;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      apply(2'b00, 0, 0, 0, 5'(i), 5'(31 - i));
      expect_val("reset_rs", 0, 0);
      expect_val("reset_rt", 1, 0);
      if (i == 0) expect_val("reset_count", 4, 0);
      drain();
    end
    apply(2'b10, 0, 32'h1234_5678, 5, 5, 0);
    expect_val("alu_we", 2, 1);
    expect_val("alu_wbdata", 3, 32'h1234_5678);
    expect_val("alu_bypass", 0, 32'h1234_5678);
    drain();
    apply(2'b00, 0, 0, 0, 5, 0);
    expect_val("alu_stored", 0, 32'h1234_5678);
    expect_val("alu_count", 4, 1);
    drain();
    apply(2'b11, 32'hDEAD_BEEF, 32'h1, 31, 31, 31);
    expect_val("mem_wbdata", 3, 32'hDEAD_BEEF);
    expect_val("mem_bypass_rs", 0, 32'hDEAD_BEEF);
    expect_val("mem_bypass_rt", 1, 32'hDEAD_BEEF);
    drain();
    apply(2'b00, 0, 0, 0, 31, 31);
    expect_val("mem_stored_rs", 0, 32'hDEAD_BEEF);
    expect_val("mem_stored_rt", 1, 32'hDEAD_BEEF);
    expect_val("mem_count", 4, 2);
    drain();
    apply(2'b10, 0, 32'hFFFF_FFFF, 0, 0, 0);
    expect_val("r0_we", 2, 0);
    expect_val("r0_rs", 0, 0);
    expect_val("r0_rt", 1, 0);
    drain();
    apply(2'b00, 0, 32'hAAAA, 7, 7, 0);
    expect_val("r0_count", 4, 2);
    expect_val("nowe_we", 2, 0);
    expect_val("nowe_wbdata", 3, 32'hAAAA);
    expect_val("nowe_bypass", 0, 0);
    drain();
    apply(2'b00, 0, 0, 0, 7, 0);
    expect_val("nowe_stored", 0, 0);
    expect_val("nowe_count", 4, 2);
    drain();
    apply(2'b00, 0, 0, 0, 5, 31);
    expect_val("indep_rs", 0, 32'h1234_5678);
    expect_val("indep_rt", 1, 32'hDEAD_BEEF);
    drain();
    apply(2'b10, 0, 32'h55, 3, 3, 0);
    drain();
    apply(2'b10, 0, 32'h77, 4, 3, 4);
    expect_val("pre_rst_r3", 0, 32'h55);
    expect_val("pre_rst_count", 4, 3);
    drain();
    // Assert reset between edges while a write to r4 is still pending.
    @(posedge clk);
    #1 rst_n = 0;
    expect_val("rst_r3", 0, 0);
    expect_val("rst_bypass_r4", 1, 32'h77);
    expect_val("rst_count", 4, 0);
    drain();
    @(posedge clk);
    #1 rst_n = 1;
    wb_ctrl = 2'b00;
    expect_val("post_rst_r3", 0, 0);
    expect_val("post_rst_r4", 1, 0);
    expect_val("post_rst_count", 4, 0);
    drain();
    apply(2'b10, 0, 32'h9, 1, 0, 0);
    drain();
    apply(2'b00, 0, 0, 0, 1, 4);
    expect_val("first_write", 0, 32'h9);
    expect_val("first_write_r4", 1, 0);
    expect_val("first_count", 4, 1);
    drain();
    apply(2'b10, 0, 32'hC0DE, 2, 2, 0);
    repeat (65534) @(posedge clk);
    #1;
    expect_val("count_max", 4, 32'hFFFF);
    drain();
    @(posedge clk);
    #1 wb_ctrl = 2'b00;
    expect_val("count_wrap", 4, 0);
    expect_val("wrap_r2", 0, 32'hC0DE);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
